reorder_buffer: RTL and testbench

//  In-order retirement stage directly upstream of the register file.
//  - Allocates 5-bit rename tags at dispatch and captures CDB results.
//  - Commits results in program order through register-file write port 2 as {state, value}.
//  - Raises flush on a mispredicted head, which also clears all register-file tags.
//  - Tag 0 means "architectural / not renamed"; ROB entry i owns tag i+1.

---
 rtl/rob_pkg.sv | 28 ++
 rtl/rob_latest_table.sv | 40 ++++
 rtl/reorder_buffer.sv | 218 +++++++++++++++++++++
 tb/tb_reorder_buffer.sv | 335 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rob_pkg.sv
// Shared types and helpers for the reorder buffer.
// Tag 0 means "architectural / not renamed"; ROB entry i owns tag i+1.
package rob_pkg;

    localparam int TAG_W  = 5;
    localparam int DATA_W = 32;
    localparam int REG_W  = 5;
    localparam logic [TAG_W-1:0] TAG_NONE = 5'd0;

    typedef struct packed {
        logic              busy;
        logic              done;
        logic              has_rd;
        logic [REG_W-1:0]  rd;
        logic [DATA_W-1:0] value;
        logic              mispred;
        logic [DATA_W-1:0] target;
    } rob_entry_t;

    function automatic logic [TAG_W-1:0] idx2tag(input logic [TAG_W-1:0] idx);
        return idx + TAG_W'(1);
    endfunction

    function automatic logic [TAG_W-1:0] tag2idx(input logic [TAG_W-1:0] tag);
        return tag - TAG_W'(1);
    endfunction

endpackage

// File: rtl/rob_latest_table.sv
// Latest-writer map: for each architectural register, the tag of the youngest
// in-flight producer (TAG_NONE when the register file holds the live value).
// One allocation write port and one commit-clear port; allocation wins when
// both address the same register in one cycle.
module rob_latest_table
    import rob_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_i,
    input  logic             alloc_we_i,
    input  logic [REG_W-1:0] alloc_rd_i,
    input  logic [TAG_W-1:0] alloc_tag_i,
    input  logic             clr_we_i,
    input  logic [REG_W-1:0] clr_rd_i,
    input  logic [REG_W-1:0] rd_addr_i,
    output logic [TAG_W-1:0] rd_tag_o
);

    logic [TAG_W-1:0] tab_q [2**REG_W];

    // Table update: synchronous wipe on reset/flush, else clear then allocate.
    always_ff @(posedge clk) begin
        if (rst || clr_i) begin
            for (int i = 0; i < 2**REG_W; i++) begin
                tab_q[i] <= TAG_NONE;
            end
        end else begin
            if (clr_we_i && !(alloc_we_i && (alloc_rd_i == clr_rd_i))) begin
                tab_q[clr_rd_i] <= TAG_NONE;
            end
            if (alloc_we_i) begin
                tab_q[alloc_rd_i] <= alloc_tag_i;
            end
        end
    end

    assign rd_tag_o = tab_q[rd_addr_i];

endmodule

// File: rtl/reorder_buffer.sv
// Reorder buffer: allocates rename tags at dispatch, captures CDB results and
// retires in program order through register-file write port 2 as {state, value}.
// A mispredicted head raises a one-cycle flush that empties the buffer.
// Optional feature macro: ROB_RETIRE_CNT_EN adds retire_count[31:0].
//
// Handshake: an allocation happens on a cycle where alloc_valid && alloc_ready;
// alloc_tag is the tag granted to that request and alloc_valid is ignored while
// alloc_ready is low. rdy low freezes all state and forces every enable to 0.
module reorder_buffer
    import rob_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              alloc_valid,
    input  logic              alloc_has_rd,
    input  logic [REG_W-1:0]  alloc_rd,
    output logic              alloc_ready,
    output logic [TAG_W-1:0]  alloc_tag,
    input  logic              cdb_valid,
    input  logic [TAG_W-1:0]  cdb_tag,
    input  logic [DATA_W-1:0] cdb_value,
    input  logic              cdb_mispred,
    input  logic [DATA_W-1:0] cdb_target,
    input  logic [TAG_W-1:0]  q1_tag,
    input  logic [TAG_W-1:0]  q2_tag,
    output logic              q1_ready,
    output logic              q2_ready,
    output logic [DATA_W-1:0] q1_value,
    output logic [DATA_W-1:0] q2_value,
    output logic              rf_we,
    output logic [REG_W-1:0]  rf_waddr,
    output logic [36:0]       rf_wdata,
    output logic              flush,
    output logic [DATA_W-1:0] flush_pc
`ifdef ROB_RETIRE_CNT_EN
    ,
    output logic [31:0]       retire_count
`endif
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    rob_entry_t        entries_q [DEPTH];
    logic [IDX_W-1:0]  head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              rf_we_q, flush_q;
    logic [REG_W-1:0]  rf_waddr_q;
    logic [36:0]       rf_wdata_q;
    logic [DATA_W-1:0] flush_pc_q;

    rob_entry_t        head_e;
    logic [TAG_W-1:0]  head_tag, latest_rd, eff_tag, new_state;
    logic              alloc_fire, commit_en, wb_en, clr_we;
    logic [IDX_W-1:0]  cdb_idx;

    function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] p);
        return (p == IDX_W'(DEPTH - 1)) ? '0 : p + IDX_W'(1);
    endfunction

    assign head_e      = entries_q[head_q];
    assign head_tag    = idx2tag(TAG_W'(head_q));
    assign alloc_tag   = idx2tag(TAG_W'(tail_q));
    assign alloc_ready = rdy && !flush_q && (count_q != CNT_W'(DEPTH));
    assign alloc_fire  = alloc_valid && alloc_ready;
    // done is sampled from registers, so a same-cycle CDB to the head waits a cycle.
    assign commit_en   = rdy && !flush_q && head_e.busy && head_e.done;
    assign cdb_idx     = IDX_W'(tag2idx(cdb_tag));
    assign wb_en       = rdy && !flush_q && cdb_valid && (cdb_tag != TAG_NONE) &&
                         (cdb_tag <= TAG_W'(DEPTH)) && entries_q[cdb_idx].busy;

    rob_latest_table u_latest (
        .clk         (clk),
        .rst         (rst),
        .clr_i       (flush_q),
        .alloc_we_i  (alloc_fire && alloc_has_rd),
        .alloc_rd_i  (alloc_rd),
        .alloc_tag_i (alloc_tag),
        .clr_we_i    (clr_we),
        .clr_rd_i    (head_e.rd),
        .rd_addr_i   (head_e.rd),
        .rd_tag_o    (latest_rd)
    );

    // Commit state: a same-cycle allocation of the same rd supersedes the table.
    always_comb begin
        eff_tag = latest_rd;
        if (alloc_fire && alloc_has_rd && (alloc_rd == head_e.rd)) begin
            eff_tag = alloc_tag;
        end
        new_state = (eff_tag == head_tag) ? TAG_NONE : eff_tag;
        clr_we    = commit_en && head_e.has_rd && (latest_rd == head_tag);
    end

    // Pointer and occupancy next-state.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (commit_en)  head_d = wrap_inc(head_q);
        if (alloc_fire) tail_d = wrap_inc(tail_q);
        case ({alloc_fire, commit_en})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer registers; a flush empties the buffer even if rdy has dropped,
    // since the register file has already seen the flush.
    always_ff @(posedge clk) begin
        if (rst || flush_q) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Entry storage: writeback, allocation at tail, release at head.
    always_ff @(posedge clk) begin
        if (rst || flush_q) begin
            for (int i = 0; i < DEPTH; i++) begin
                entries_q[i] <= '0;
            end
        end else begin
            if (wb_en) begin
                entries_q[cdb_idx].done    <= 1'b1;
                entries_q[cdb_idx].value   <= cdb_value;
                entries_q[cdb_idx].mispred <= cdb_mispred;
                entries_q[cdb_idx].target  <= cdb_target;
            end
            if (alloc_fire) begin
                entries_q[tail_q] <= '{busy: 1'b1, done: 1'b0, has_rd: alloc_has_rd,
                                       rd: alloc_rd, value: '0, mispred: 1'b0, target: '0};
            end
            if (commit_en) begin
                entries_q[head_q].busy <= 1'b0;
                entries_q[head_q].done <= 1'b0;
            end
        end
    end

    // Registered retire port and flush pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            rf_we_q    <= 1'b0;
            rf_waddr_q <= '0;
            rf_wdata_q <= '0;
            flush_q    <= 1'b0;
            flush_pc_q <= '0;
        end else if (flush_q || !rdy) begin
            rf_we_q <= 1'b0;
            flush_q <= 1'b0;
        end else begin
            rf_we_q <= commit_en && head_e.has_rd && (head_e.rd != '0);
            flush_q <= commit_en && head_e.mispred;
            if (commit_en) begin
                rf_waddr_q <= head_e.rd;
                rf_wdata_q <= {new_state, head_e.value};
            end
            if (commit_en && head_e.mispred) begin
                flush_pc_q <= head_e.target;
            end
        end
    end

    assign rf_we    = rf_we_q;
    assign rf_waddr = rf_waddr_q;
    assign rf_wdata = rf_wdata_q;
    assign flush    = flush_q;
    assign flush_pc = flush_pc_q;

    // Operand lookup with same-cycle CDB bypass; tag 0 or out of range is never ready.
    logic [1:0][TAG_W-1:0]  q_tag;
    logic [1:0]             q_rdy;
    logic [1:0][DATA_W-1:0] q_val;
    rob_entry_t             q_e;
    assign q_tag = {q2_tag, q1_tag};
    always_comb begin
        q_rdy = '0;
        q_val = '0;
        q_e   = '0;
        for (int k = 0; k < 2; k++) begin
            q_e = entries_q[IDX_W'(tag2idx(q_tag[k]))];
            if ((q_tag[k] != TAG_NONE) && (q_tag[k] <= TAG_W'(DEPTH)) && q_e.busy) begin
                if (q_e.done) begin
                    q_rdy[k] = 1'b1;
                    q_val[k] = q_e.value;
                end else if (cdb_valid && (cdb_tag == q_tag[k])) begin
                    q_rdy[k] = 1'b1;
                    q_val[k] = cdb_value;
                end
            end
        end
    end
    assign q1_ready = q_rdy[0];
    assign q2_ready = q_rdy[1];
    assign q1_value = q_val[0];
    assign q2_value = q_val[1];

`ifdef ROB_RETIRE_CNT_EN
    logic [31:0] retire_cnt_q;
    // Retired-entry counter; only rst clears it.
    always_ff @(posedge clk) begin
        if (rst)            retire_cnt_q <= '0;
        else if (commit_en) retire_cnt_q <= retire_cnt_q + 32'd1;
    end
    assign retire_count = retire_cnt_q;
`endif

endmodule

// File: tb/tb_reorder_buffer.sv
// Bench for reorder_buffer: directed scenarios followed by random traffic,
// all checked against a queue-based model of in-order retirement.
module tb_reorder_buffer;

    localparam int DEPTH = 16;

    logic        clk, rst, rdy;
    logic        alloc_valid, alloc_has_rd;
    logic [4:0]  alloc_rd, alloc_tag;
    logic        alloc_ready;
    logic        cdb_valid, cdb_mispred;
    logic [4:0]  cdb_tag;
    logic [31:0] cdb_value, cdb_target;
    logic [4:0]  q1_tag, q2_tag;
    logic        q1_ready, q2_ready;
    logic [31:0] q1_value, q2_value;
    logic        rf_we, flush;
    logic [4:0]  rf_waddr;
    logic [36:0] rf_wdata;
    logic [31:0] flush_pc;
`ifdef ROB_RETIRE_CNT_EN
    logic [31:0] retire_count;
`endif

    // clock / reset block
    initial clk = 1'b0;
    always #5 clk = ~clk;

    reorder_buffer #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .rdy(rdy),
        .alloc_valid(alloc_valid), .alloc_has_rd(alloc_has_rd), .alloc_rd(alloc_rd),
        .alloc_ready(alloc_ready), .alloc_tag(alloc_tag),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value),
        .cdb_mispred(cdb_mispred), .cdb_target(cdb_target),
        .q1_tag(q1_tag), .q2_tag(q2_tag), .q1_ready(q1_ready), .q2_ready(q2_ready),
        .q1_value(q1_value), .q2_value(q2_value),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .flush(flush), .flush_pc(flush_pc)
`ifdef ROB_RETIRE_CNT_EN
        , .retire_count(retire_count)
`endif
    );

    typedef struct packed {
        logic        rst_chk;
        logic        we;
        logic [4:0]  waddr;
        logic [36:0] wdata;
        logic        fl;
        logic [31:0] fpc;
    } exp_t;

    typedef struct {
        logic [4:0]  tag;
        logic        has_rd;
        logic [4:0]  rd;
        logic        done;
        logic [31:0] value;
        logic        mis;
        logic [31:0] tgt;
    } m_ent_t;

    exp_t       exp_q[$];
    m_ent_t     rob_m[$];
    logic [4:0] latest_m [32];
    logic [4:0] next_tag_m;
    logic       flush_m;
    int         commits_m;
    int         checks, errors;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: operand lookup over the in-flight program-order list.
    task automatic model_lookup(input logic [4:0] t, output logic r, output logic [31:0] v);
        r = 1'b0;
        v = '0;
        if (t != 5'd0) begin
            foreach (rob_m[i]) begin
                if (rob_m[i].tag == t) begin
                    if (rob_m[i].done) begin
                        r = 1'b1; v = rob_m[i].value;
                    end else if (cdb_valid && cdb_tag == t) begin
                        r = 1'b1; v = cdb_value;
                    end
                end
            end
        end
    endtask

    task automatic model_clear();
        rob_m.delete();
        for (int i = 0; i < 32; i++) latest_m[i] = 5'd0;
        next_tag_m = 5'd1;
        flush_m    = 1'b0;
    endtask

    task automatic model_comb_checks();
        logic r;
        logic [31:0] v;
        chk("alloc_ready", alloc_ready, rdy && !flush_m && (rob_m.size() < DEPTH));
        chk("alloc_tag", alloc_tag, next_tag_m);
        model_lookup(q1_tag, r, v);
        chk("q1_ready", q1_ready, r);
        chk("q1_value", q1_value, v);
        model_lookup(q2_tag, r, v);
        chk("q2_ready", q2_ready, r);
        chk("q2_value", q2_value, v);
    endtask

    // Model: what the next posedge does, pushed to the scoreboard.
    task automatic model_step();
        exp_t       e;
        m_ent_t     h;
        m_ent_t     n;
        logic [4:0] nt;
        logic [4:0] eff;
        bit         a_ok;
        e  = '0;
        nt = next_tag_m;
        if (rst) begin
            model_clear();
            e.rst_chk = 1'b1;
        end else if (flush_m) begin
            model_clear();
        end else if (rdy) begin
            a_ok = alloc_valid && (rob_m.size() < DEPTH);
            if (rob_m.size() > 0 && rob_m[0].done) begin
                h   = rob_m.pop_front();
                eff = (a_ok && alloc_has_rd && alloc_rd == h.rd) ? nt : latest_m[h.rd];
                e.we    = h.has_rd && (h.rd != 5'd0);
                e.waddr = h.rd;
                e.wdata = {(eff == h.tag) ? 5'd0 : eff, h.value};
                e.fl    = h.mis;
                e.fpc   = h.tgt;
                if (h.has_rd && latest_m[h.rd] == h.tag) latest_m[h.rd] = 5'd0;
                flush_m = h.mis;
                commits_m++;
            end
            if (cdb_valid && cdb_tag != 5'd0) begin
                foreach (rob_m[i]) begin
                    if (rob_m[i].tag == cdb_tag) begin
                        rob_m[i].done  = 1'b1;
                        rob_m[i].value = cdb_value;
                        rob_m[i].mis   = cdb_mispred;
                        rob_m[i].tgt   = cdb_target;
                    end
                end
            end
            if (a_ok) begin
                n = '{tag: nt, has_rd: alloc_has_rd, rd: alloc_rd, done: 1'b0,
                      value: 32'd0, mis: 1'b0, tgt: 32'd0};
                rob_m.push_back(n);
                if (alloc_has_rd) latest_m[alloc_rd] = nt;
                next_tag_m = (nt == 5'(DEPTH)) ? 5'd1 : nt + 5'd1;
            end
        end
        exp_q.push_back(e);
    endtask

    // Driver: apply one cycle of inputs, check combinational outputs, predict the edge.
    task automatic tick(input bit r, input bit ry, input bit av, input bit ahr,
                        input logic [4:0] ard, input bit cv, input logic [4:0] ct,
                        input logic [31:0] cval, input bit cm, input logic [31:0] ctg,
                        input logic [4:0] q1, input logic [4:0] q2);
        rst = r; rdy = ry;
        alloc_valid = av; alloc_has_rd = ahr; alloc_rd = ard;
        cdb_valid = cv; cdb_tag = ct; cdb_value = cval; cdb_mispred = cm; cdb_target = ctg;
        q1_tag = q1; q2_tag = q2;
        #1;
        if (!r) model_comb_checks();
        model_step();
        @(negedge clk);
    endtask

    task automatic do_reset();
        for (int i = 0; i < 2; i++) tick(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask
    task automatic alloc(input logic [4:0] rd);
        tick(0, 1, 1, 1, rd, 0, 0, 0, 0, 0, 0, 0);
    endtask
    task automatic cdb(input logic [4:0] t, input logic [31:0] v, input bit m, input logic [31:0] tg);
        tick(0, 1, 0, 0, 0, 1, t, v, m, tg, 0, 0);
    endtask
    task automatic idle();
        tick(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // Scoreboard monitor: one expected record per posedge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                if (e.rst_chk) begin
                    chk("rst_rf_we", rf_we, 0);
                    chk("rst_rf_waddr", rf_waddr, 0);
                    chk("rst_rf_wdata", rf_wdata, 0);
                    chk("rst_flush", flush, 0);
                    chk("rst_flush_pc", flush_pc, 0);
                end else begin
                    chk("rf_we", rf_we, e.we);
                    chk("flush", flush, e.fl);
                    if (e.we) begin
                        chk("rf_waddr", rf_waddr, e.waddr);
                        chk("rf_wdata", rf_wdata, e.wdata);
                    end
                    if (e.fl) chk("flush_pc", flush_pc, e.fpc);
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bit         r_rst, r_rdy, r_av, r_ahr, r_cv, r_cm;
        logic [4:0] r_rd, r_ct, r_q1, r_q2;
        int         sel;
        checks = 0; errors = 0; commits_m = 0;
        model_clear();

        // 1: single result retires one cycle after the CDB
        do_reset();
        alloc(5'd5);
        cdb(5'd1, 32'h1234, 0, 0);
        idle();
        chk("t1_we", rf_we, 1);
        chk("t1_waddr", rf_waddr, 5);
        chk("t1_wdata", rf_wdata, {5'd0, 32'h1234});

        // 2: older writer retires with the younger tag as state
        do_reset();
        alloc(5'd7);
        alloc(5'd7);
        cdb(5'd1, 32'h11, 0, 0);
        idle();
        chk("t2_state_younger", rf_wdata[36:32], 2);
        cdb(5'd2, 32'h22, 0, 0);
        idle();
        chk("t2_state_cleared", rf_wdata, {5'd0, 32'h22});

        // 3: full and wrap
        do_reset();
        for (int i = 0; i < DEPTH; i++) alloc(5'd3);
        chk("t3_full_ready", alloc_ready, 0);
        cdb(5'd1, 32'h33, 0, 0);
        idle();
        chk("t3_after_commit_ready", alloc_ready, 1);
        chk("t3_wrap_tag", alloc_tag, 1);
        alloc(5'd3);

        // 4: mispredicted head flushes
        do_reset();
        alloc(5'd1);
        alloc(5'd2);
        alloc(5'd3);
        cdb(5'd1, 32'h5, 1, 32'h80);
        idle();
        chk("t4_flush", flush, 1);
        chk("t4_flush_pc", flush_pc, 32'h80);
        chk("t4_we", rf_we, 1);
        idle();
        chk("t4_tag_after_flush", alloc_tag, 1);
        chk("t4_ready_after_flush", alloc_ready, 1);

        // 5: operand bypass and tag 0
        do_reset();
        alloc(5'd1);
        alloc(5'd2);
        alloc(5'd3);
        tick(0, 1, 0, 0, 0, 1, 5'd3, 32'hAB, 0, 0, 5'd3, 5'd0);
        tick(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 5'd0, 5'd3);
        chk("t5_q1_tag0", q1_ready, 0);

        // 6: rdy freeze, then reset over a pending mispredict
        do_reset();
        alloc(5'd4);
        cdb(5'd1, 32'h44, 0, 0);
        for (int i = 0; i < 3; i++) begin
            tick(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 5'd1, 5'd0);
            chk("t6_frozen_we", rf_we, 0);
        end
        chk("t6_head_kept", q1_value, 32'h44);
        alloc(5'd6);
        cdb(5'd2, 32'h66, 1, 32'h100);
        tick(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("t6_rst_flush", flush, 0);
        idle();

        // random traffic
        for (int c = 0; c < 3000; c++) begin
            r_rst = ($urandom_range(0, 399) == 0);
            r_rdy = ($urandom_range(0, 9) != 0);
            r_av  = ($urandom_range(0, 9) < 6);
            r_ahr = ($urandom_range(0, 9) < 8);
            r_rd  = 5'($urandom_range(0, 7));
            sel   = $urandom_range(0, 9);
            r_cv  = 1'b0;
            r_ct  = 5'd0;
            if (sel < 5 && rob_m.size() > 0) begin
                r_cv = 1'b1;
                r_ct = rob_m[$urandom_range(0, rob_m.size() - 1)].tag;
            end else if (sel == 5) begin
                r_cv = 1'b1;
                r_ct = 5'($urandom_range(0, 31));
            end
            r_cm = ($urandom_range(0, 11) == 0);
            r_q1 = 5'($urandom_range(0, 17));
            r_q2 = ($urandom_range(0, 1) == 0) ? r_ct : 5'($urandom_range(0, 17));
            tick(r_rst, r_rdy, r_av, r_ahr, r_rd, r_cv, r_ct, $urandom, r_cm, $urandom,
                 r_q1, r_q2);
        end
        idle();
        chk("scoreboard_drained", exp_q.size(), 0);
`ifdef ROB_RETIRE_CNT_EN
        chk("retire_count", retire_count, 32'(commits_m));
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
